// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder sequencer sharing one full-adder cell, LSB first
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_in;
    logic             w_carry_init;
    logic             w_ha0_s;
    logic             w_ha0_c;
    logic             w_ha1_c;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_part_next;

    // Subtraction is a + ~b + 1: invert b once at capture and seed the carry.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_in       = sub ? ~b : b;
    assign w_carry_init = sub;
`else
    assign w_b_in       = b;
    assign w_carry_init = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == LAST_BIT);

    half_adder u_ha0 (
        .i_x (r_a_sr[0]),
        .i_y (r_b_sr[0]),
        .o_s (w_ha0_s),
        .o_c (w_ha0_c)
    );

    half_adder u_ha1 (
        .i_x (w_ha0_s),
        .i_y (r_carry),
        .o_s (w_fa_sum),
        .o_c (w_ha1_c)
    );

    assign w_fa_cout   = w_ha0_c | w_ha1_c;
    assign w_part_next = {w_fa_sum, r_part[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Results only move on the final bit edge, so sum/carry_out hold through a new RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_part  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_in;
            r_part  <= '0;
            r_cnt   <= '0;
            r_carry <= w_carry_init;
        end else if (r_state == S_RUN) begin
            r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_part  <= w_part_next;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_part_next;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule

module half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents operands with start for one edge; returns at the negedge just after the accepting edge.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", carry_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        start_op(8'd3, 8'd5);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL basic_run cyc=%0d got busy=%b done=%b exp busy=1 done=0", i, busy, done);
            end
            @(negedge clk);
        end
        total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL basic_done got busy=%b done=%b exp busy=0 done=1", busy, done); end
        total++; if (sum !== 8'h08) begin bad++; $display("FAIL basic_sum got=%h exp=08", sum); end
        total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b exp=0", carry_out); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_after got busy=%b done=%b exp 0 0", busy, done); end
        total++; if (sum !== 8'h08) begin bad++; $display("FAIL basic_hold got=%h exp=08", sum); end
    endtask

    task automatic test_carry;
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] vs [4];
        logic       vc [4];
        int         cyc;
        bit         ok;
        va[0] = 8'hFF; vb[0] = 8'h01; vs[0] = 8'h00; vc[0] = 1'b1;
        va[1] = 8'hFF; vb[1] = 8'hFF; vs[1] = 8'hFE; vc[1] = 1'b1;
        va[2] = 8'hA5; vb[2] = 8'h5A; vs[2] = 8'hFF; vc[2] = 1'b0;
        va[3] = 8'h80; vb[3] = 8'h80; vs[3] = 8'h00; vc[3] = 1'b1;
        for (int v = 0; v < 4; v++) begin
            start_op(va[v], vb[v]);
            wait_done(cyc, ok);
            total++; if (!ok || cyc != 8) begin bad++; $display("FAIL carry_latency v=%0d got cyc=%0d ok=%0d exp cyc=8", v, cyc, ok); end
            total++; if (sum !== vs[v] || carry_out !== vc[v]) begin
                bad++; $display("FAIL carry_result v=%0d got sum=%h cout=%b exp sum=%h cout=%b", v, sum, carry_out, vs[v], vc[v]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_ignore;
        logic [7:0] prev;
        prev = sum;
        start_op(8'h12, 8'h34);
        for (int i = 0; i < 8; i++) begin
            a     = 8'($urandom);
            b     = 8'($urandom);
            start = i[0];
            total++; if (sum !== prev) begin bad++; $display("FAIL hold_sum cyc=%0d got=%h exp=%h", i, sum, prev); end
            @(negedge clk);
        end
        start = 1'b1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL hold_done got=%b exp=1", done); end
        total++; if (sum !== 8'h46 || carry_out !== 1'b0) begin
            bad++; $display("FAIL hold_result got sum=%h cout=%b exp sum=46 cout=0", sum, carry_out);
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (busy !== 1'b0 || done !== 1'b0) begin
                bad++; $display("FAIL hold_no_extra cyc=%0d got busy=%b done=%b exp 0 0", i, busy, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int npulse;
        int last_idx;
        @(negedge clk);
        a        = 8'h10;
        b        = 8'h20;
        start    = 1'b1;
        npulse   = 0;
        last_idx = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                total++; if (sum !== 8'h30 || carry_out !== 1'b0) begin
                    bad++; $display("FAIL b2b_result idx=%0d got sum=%h cout=%b exp sum=30 cout=0", i, sum, carry_out);
                end
                if (last_idx >= 0) begin
                    total++; if (i - last_idx != 10) begin bad++; $display("FAIL b2b_interval got=%0d exp=10", i - last_idx); end
                end
                last_idx = i;
                npulse++;
            end
        end
        start = 1'b0;
        total++; if (npulse != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", npulse); end
        repeat (12) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit ok;
        int seen;
        start_op(8'h0F, 8'h01);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmid_ctrl got busy=%b done=%b exp 0 0", busy, done); end
        total++; if (sum !== 8'h00 || carry_out !== 1'b0) begin
            bad++; $display("FAIL rmid_clear got sum=%h cout=%b exp sum=00 cout=0", sum, carry_out);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rmid_ghost got activity=%0d exp=0", seen); end
        start_op(8'h0F, 8'h01);
        wait_done(cyc, ok);
        total++; if (!ok || cyc != 8) begin bad++; $display("FAIL rmid_latency got cyc=%0d ok=%0d exp cyc=8", cyc, ok); end
        total++; if (sum !== 8'h10 || carry_out !== 1'b0) begin
            bad++; $display("FAIL rmid_result got sum=%h cout=%b exp sum=10 cout=0", sum, carry_out);
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int cyc;
        bit ok;
        sub = 1'b1;
        start_op(8'd5, 8'd7);
        sub = 1'b0;
        wait_done(cyc, ok);
        total++; if (!ok || sum !== 8'hFE || carry_out !== 1'b0) begin
            bad++; $display("FAIL sub_borrow got sum=%h cout=%b ok=%0d exp sum=fe cout=0", sum, carry_out, ok);
        end
        @(negedge clk);
        sub = 1'b1;
        start_op(8'd9, 8'd4);
        sub = 1'b0;
        wait_done(cyc, ok);
        total++; if (!ok || sum !== 8'h05 || carry_out !== 1'b1) begin
            bad++; $display("FAIL sub_noborrow got sum=%h cout=%b ok=%0d exp sum=05 cout=1", sum, carry_out, ok);
        end
        @(negedge clk);
        start_op(8'd9, 8'd4);
        wait_done(cyc, ok);
        total++; if (!ok || sum !== 8'h0D || carry_out !== 1'b0) begin
            bad++; $display("FAIL sub_addmode got sum=%h cout=%b ok=%0d exp sum=0d cout=0", sum, carry_out, ok);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        test_reset;
        test_basic;
        test_carry;
        test_hold_ignore;
        test_back_to_back;
        test_reset_mid;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
